spi_cmd_decoder: RTL and testbench

Consumes the byte stream delivered by the SPI slave receiver and turns it into text-mode character RAM writes and cursor updates for the VGA text driver. Sits between the SPI receive stage (rx byte, done level, synchronised chip select) and the character/attribute RAM write port. Implements a three-command protocol (set cursor, write char, clear screen) with an internal cursor, wrap-around and a hardware screen fill.

---
 rtl/spi_cmd_decoder.sv | 195 +++++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// ============================================================================
// Module   : spi_cmd_decoder
// Purpose  : Decodes SPI command bytes into text-RAM writes, cursor moves and
//            a full-screen hardware clear for the VGA text driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_cmd_decoder #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_byte,
    input  logic              rx_done,
    input  logic              cs_sync,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              busy,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARG1  = 2'd1,
        S_ARG2  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    localparam logic [1:0]        OP_SET     = 2'd1;
    localparam logic [1:0]        OP_CLR     = 2'd3;
    localparam logic [ADDR_W-1:0] C_COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] C_LAST_A   = ADDR_W'(COLS * ROWS - 1);
    localparam logic [6:0]        C_LAST_COL = 7'(COLS - 1);
    localparam logic [4:0]        C_LAST_ROW = 5'(ROWS - 1);

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [7:0]          arg1_q, arg1_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                rx_done_q, cs_q;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [15:0]         ram_wdata_q, ram_wdata_d;
    logic                busy_q, busy_d;
    logic [6:0]          col_q, col_d;
    logic [4:0]          row_q, row_d;
    logic                err_q, err_d;

    logic                strobe;
    logic                frame_end;
    logic [ADDR_W-1:0]   cur_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 2'd0;
            arg1_q      <= 8'd0;
            cnt_q       <= '0;
            rx_done_q   <= 1'b1;
            cs_q        <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 16'd0;
            busy_q      <= 1'b0;
            col_q       <= 7'd0;
            row_q       <= 5'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            arg1_q      <= arg1_d;
            cnt_q       <= cnt_d;
            rx_done_q   <= rx_done;
            cs_q        <= cs_sync;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            busy_q      <= busy_d;
            col_q       <= col_d;
            row_q       <= row_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        strobe      = rx_done & ~rx_done_q;
        frame_end   = cs_sync & ~cs_q;
        cur_addr    = ADDR_W'(row_q) * C_COLS_A + ADDR_W'(col_q);

        state_d     = state_q;
        op_d        = op_q;
        arg1_d      = arg1_q;
        cnt_d       = cnt_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        busy_d      = busy_q;
        col_d       = col_q;
        row_d       = row_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    case (rx_byte)
                        8'h01, 8'h02, 8'h03: begin
                            op_d    = rx_byte[1:0];
                            state_d = S_ARG1;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_ARG1: begin
                if (strobe) begin
                    arg1_d = rx_byte;
                    if (op_q == OP_CLR) begin
                        // First fill write is issued here so the burst starts the next cycle
                        cnt_d       = '0;
                        ram_we_d    = 1'b1;
                        ram_addr_d  = '0;
                        ram_wdata_d = {rx_byte, 8'h20};
                        busy_d      = 1'b1;
                        state_d     = S_CLEAR;
                    end else begin
                        state_d = S_ARG2;
                    end
                end
            end
            S_ARG2: begin
                if (strobe) begin
                    state_d = S_IDLE;
                    if (op_q == OP_SET) begin
                        if ((int'(arg1_q) < COLS) && (int'(rx_byte) < ROWS)) begin
                            col_d = arg1_q[6:0];
                            row_d = rx_byte[4:0];
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        ram_we_d    = 1'b1;
                        ram_addr_d  = cur_addr;
                        ram_wdata_d = {rx_byte, arg1_q};
                        if (col_q == C_LAST_COL) begin
                            col_d = 7'd0;
                            row_d = (row_q == C_LAST_ROW) ? 5'd0 : row_q + 5'd1;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end
                end
            end
            S_CLEAR: begin
                if (strobe) begin
                    err_d = 1'b1;
                end
                if (cnt_q == C_LAST_A) begin
                    busy_d  = 1'b0;
                    col_d   = 7'd0;
                    row_d   = 5'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d       = cnt_q + ADDR_W'(1);
                    ram_we_d    = 1'b1;
                    ram_addr_d  = cnt_q + ADDR_W'(1);
                    ram_wdata_d = {arg1_q, 8'h20};
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A frame ending with a command still incomplete (after this cycle's byte) is aborted
        if (frame_end && ((state_d == S_ARG1) || (state_d == S_ARG2))) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign busy       = busy_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_decoder.sv
// ============================================================================
// Module   : tb_spi_cmd_decoder
// Purpose  : Scoreboard bench for spi_cmd_decoder: expected RAM writes are
//            queued as commands are sent and matched as the DUT writes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_cmd_decoder;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 12;
    localparam int CELLS  = COLS * ROWS;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_byte;
    logic              rx_done;
    logic              cs_sync;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic              busy;
    logic [6:0]        cursor_col;
    logic [4:0]        cursor_row;
    logic              err;

    int total = 0;
    int bad   = 0;
    int err_cnt  = 0;
    int exp_err  = 0;
    int busy_cnt = 0;
    logic [27:0] exp_q[$];

    spi_cmd_decoder #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx_byte    (rx_byte),
        .rx_done    (rx_done),
        .cs_sync    (cs_sync),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .busy       (busy),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        logic [27:0] e;
        if (err)  err_cnt++;
        if (busy) busy_cnt++;
        if (ram_we) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", {4'h0, ram_addr, ram_wdata}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_val("write", {4'h0, ram_addr, ram_wdata}, {4'h0, e});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Returns one cycle after the strobe edge, just after the monitor has sampled
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
        rx_byte = b;
        rx_done = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a);
        send_byte(b);
        send_byte(c);
    endtask

    task automatic check_cursor(input string tag, input int col, input int row);
        check_val({tag, "_col"}, 32'(cursor_col), 32'(col));
        check_val({tag, "_row"}, 32'(cursor_row), 32'(row));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_we"},    32'(ram_we),    32'd0);
        check_val({tag, "_addr"},  32'(ram_addr),  32'd0);
        check_val({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
        check_val({tag, "_busy"},  32'(busy),      32'd0);
        check_val({tag, "_err"},   32'(err),       32'd0);
        check_cursor(tag, 0, 0);
    endtask

    task automatic push_clear(input logic [7:0] attr);
        for (int i = 0; i < CELLS; i++) begin
            exp_q.push_back({12'(i), attr, 8'h20});
        end
    endtask

    task automatic wait_not_busy(input string tag);
        bit done = 0;
        for (int i = 0; i < CELLS + 200; i++) begin
            @(negedge clk);
            #1;
            if (!busy) begin
                done = 1;
                break;
            end
        end
        check_val({tag, "_done_in_time"}, 32'(done), 32'd1);
    endtask

    initial begin
        bit found;
        rst     = 1'b1;
        rx_done = 1'b1;
        rx_byte = 8'h09;
        cs_sync = 1'b1;
        idle(3);
        check_reset_outputs("reset");

        // rx_done held high through release must not strobe the bad opcode
        rst = 1'b0;
        idle(4);
        check_val("no_strobe_after_reset", 32'(err_cnt), 32'd0);
        cs_sync = 1'b0;

        send3(8'h01, 8'h05, 8'h03);
        check_cursor("set_5_3", 5, 3);
        send_byte(8'h02);
        send_byte(8'h41);
        exp_q.push_back({12'd245, 16'h1F41});
        send_byte(8'h1F);
        check_cursor("after_write", 6, 3);
        check_val("write_245_done", 32'(exp_q.size()), 32'd0);

        send3(8'h01, 8'h4F, 8'h1D);
        check_cursor("set_79_29", 79, 29);
        send_byte(8'h02);
        send_byte(8'h58);
        exp_q.push_back({12'd2399, 16'h0758});
        send_byte(8'h07);
        check_cursor("wrap", 0, 0);
        send_byte(8'h02);
        send_byte(8'h41);
        exp_q.push_back({12'd0, 16'h0741});
        send_byte(8'h07);
        check_cursor("after_wrap_write", 1, 0);
        check_val("wrap_writes_done", 32'(exp_q.size()), 32'd0);

        send_byte(8'h09);
        exp_err++;
        check_val("bad_opcode_err", 32'(err_cnt), 32'(exp_err));

        send3(8'h01, 8'h80, 8'h00);
        exp_err++;
        check_val("col_range_err", 32'(err_cnt), 32'(exp_err));
        check_cursor("col_range", 1, 0);

        send_byte(8'h02);
        send_byte(8'h41);
        cs_sync = 1'b1;
        idle(2);
        exp_err++;
        check_val("abort_err", 32'(err_cnt), 32'(exp_err));
        cs_sync = 1'b0;
        idle(1);
        send3(8'h01, 8'h00, 8'h00);
        check_cursor("after_abort", 0, 0);
        check_val("after_abort_err", 32'(err_cnt), 32'(exp_err));

        // Full clear with a byte dropped mid-fill
        send3(8'h01, 8'h05, 8'h03);
        busy_cnt = 0;
        send_byte(8'h03);
        push_clear(8'h70);
        send_byte(8'h70);
        check_val("busy_rise", 32'(busy), 32'd1);
        idle(50);
        send_byte(8'h55);
        exp_err++;
        wait_not_busy("clear");
        check_val("busy_cycles", 32'(busy_cnt), 32'(CELLS));
        check_val("clear_writes_done", 32'(exp_q.size()), 32'd0);
        check_cursor("after_clear", 0, 0);
        check_val("clear_err", 32'(err_cnt), 32'(exp_err));

        // Reset in the middle of a clear at counter 100
        send3(8'h01, 8'h05, 8'h03);
        send_byte(8'h03);
        push_clear(8'h70);
        send_byte(8'h70);
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ram_we && (ram_addr == 12'd100)) begin
                found = 1;
                break;
            end
        end
        check_val("clear_reached_100", 32'(found), 32'd1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        #1;
        check_reset_outputs("mid_clear_reset");
        rst = 1'b0;
        idle(5);
        check_val("no_write_after_reset", 32'(exp_q.size()), 32'd0);

        send_byte(8'h02);
        send_byte(8'h41);
        exp_q.push_back({12'd0, 16'h1F41});
        send_byte(8'h1F);
        check_cursor("post_reset_write", 1, 0);
        idle(5);
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);
        check_val("final_err", 32'(err_cnt), 32'(exp_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
